// File: rtl/fact_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : fact_dispatch
// Description : Memory-mapped job scheduler. Software pushes factorial
//               operands into a small FIFO; jobs are handed to four
//               factorial units in round-robin order with a one-cycle go
//               pulse, and per-unit busy state is tracked from done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module fact_dispatch #(
  parameter logic [31:0] BASE_ADDR = 32'h00070000,
  parameter int          DEPTH     = 4,
  parameter int          N_W       = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [31:0]    input_addr,
  input  logic           write_enable,
  input  logic [31:0]    write_data,
  output logic [31:0]    read_data,
  input  logic [3:0]     done,
  output logic [3:0]     unit_go,
  output logic [N_W-1:0] unit_n,
  output logic           all_idle
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N_W-1:0]   mem_q [DEPTH];
  logic [N_W-1:0]   mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [3:0]       busy_q, busy_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic             overflow_q, overflow_d;
  logic             spurious_q, spurious_d;
  logic [1:0]       last_unit_q, last_unit_d;
  logic [N_W-1:0]   last_n_q, last_n_d;
  logic [3:0]       unit_go_q, unit_go_d;
  logic [N_W-1:0]   unit_n_q, unit_n_d;

  logic             win_hit;
  logic [1:0]       offset;
  logic             push_req;
  logic             ctrl_wr;
  logic             queue_full;
  logic             do_push;
  logic             do_flush;
  logic             sel_found;
  logic [1:0]       sel_idx;
  logic [1:0]       cand;
  logic             dispatch;
  logic [3:0]       spur_hits;
  logic [3:0]       count_ext;

  // Only the upper address bits and the low data bits carry meaning here.
  logic unused_ok;
  assign unused_ok = &{1'b0, input_addr[1:0], write_data[31:N_W]};

  // Bus decode of the 16-byte register window.
  assign win_hit    = (input_addr[31:4] == BASE_ADDR[31:4]);
  assign offset     = input_addr[3:2];
  assign push_req   = write_enable & win_hit & (offset == 2'd0);
  assign ctrl_wr    = write_enable & win_hit & (offset == 2'd3);
  assign queue_full = (count_q == FULL_COUNT);
  assign do_flush   = ctrl_wr & write_data[1];
  assign do_push    = push_req & ~queue_full & ~do_flush;
  assign spur_hits  = done & ~busy_q;
  assign count_ext  = 4'(count_q);

  // Round-robin search for the first free unit starting at rr_ptr.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = rr_ptr_q;
    cand      = rr_ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = rr_ptr_q + 2'(k);
      if (!sel_found && !busy_q[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign dispatch = (state_q == S_IDLE) && (count_q != '0) && sel_found;

  // Next-state logic for the FSM, queue, busy tracking and status flags.
  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    busy_d      = busy_q & ~done;
    rr_ptr_d    = rr_ptr_q;
    overflow_d  = overflow_q;
    spurious_d  = spurious_q;
    last_unit_d = last_unit_q;
    last_n_d    = last_n_q;
    unit_go_d   = 4'b0000;
    unit_n_d    = unit_n_q;

    // Clearing first so an event in the same cycle still leaves its flag set.
    if (ctrl_wr && write_data[0]) begin
      overflow_d = 1'b0;
      spurious_d = 1'b0;
    end
    if (|spur_hits) begin
      spurious_d = 1'b1;
    end
    if (push_req && queue_full) begin
      overflow_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (dispatch) begin
          state_d          = S_ISSUE;
          unit_go_d        = 4'b0001 << sel_idx;
          unit_n_d         = mem_q[rd_ptr_q];
          busy_d[sel_idx]  = 1'b1;
          rr_ptr_d         = sel_idx + 2'd1;
          last_unit_d      = sel_idx;
          last_n_d         = mem_q[rd_ptr_q];
        end
      end
      S_ISSUE: state_d = S_GAP;
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (do_push) begin
      mem_d[wr_ptr_q] = write_data[N_W-1:0];
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (dispatch) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_push, dispatch})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Flush drops queued jobs only; a job already selected still goes out.
    if (do_flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      busy_q      <= '0;
      rr_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      spurious_q  <= 1'b0;
      last_unit_q <= '0;
      last_n_q    <= '0;
      unit_go_q   <= '0;
      unit_n_q    <= '0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      rr_ptr_q    <= rr_ptr_d;
      overflow_q  <= overflow_d;
      spurious_q  <= spurious_d;
      last_unit_q <= last_unit_d;
      last_n_q    <= last_n_d;
      unit_go_q   <= unit_go_d;
      unit_n_q    <= unit_n_d;
    end
  end

  assign unit_go  = unit_go_q;
  assign unit_n   = unit_n_q;
  assign all_idle = (count_q == '0) && (busy_q == 4'b0000) && (state_q == S_IDLE);

  // Combinational register read; zero outside the window.
  always_comb begin
    read_data = 32'h0;
    if (win_hit) begin
      case (offset)
        2'd1: begin
          read_data[3:0]   = busy_q;
          read_data[7:4]   = count_ext;
          read_data[8]     = overflow_q;
          read_data[9]     = spurious_q;
          read_data[10]    = all_idle;
          read_data[13:12] = rr_ptr_q;
        end
        2'd2: begin
          read_data[1:0]     = last_unit_q;
          read_data[N_W+7:8] = last_n_q;
        end
        default: read_data = 32'h0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fact_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_fact_dispatch
// Description : Self-checking bench for fact_dispatch. Expected dispatches
//               are queued when jobs are written and compared when unit_go
//               fires; register reads are compared against fixed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fact_dispatch;

  localparam logic [31:0] A_JOB    = 32'h00070000;
  localparam logic [31:0] A_STATUS = 32'h00070004;
  localparam logic [31:0] A_LAST   = 32'h00070008;
  localparam logic [31:0] A_CTRL   = 32'h0007000C;

  logic        clk;
  logic        rst;
  logic [31:0] input_addr;
  logic        write_enable;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic [3:0]  done;
  logic [3:0]  unit_go;
  logic [7:0]  unit_n;
  logic        all_idle;

  typedef struct packed {
    logic [1:0] unit;
    logic [7:0] n;
  } job_t;

  job_t sb[$];
  int   go_times[$];
  int   cyc;
  int   checks;
  int   errors;
  logic found;

  fact_dispatch #(
    .BASE_ADDR(32'h00070000),
    .DEPTH    (4),
    .N_W      (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .input_addr  (input_addr),
    .write_enable(write_enable),
    .write_data  (write_data),
    .read_data   (read_data),
    .done        (done),
    .unit_go     (unit_go),
    .unit_n      (unit_n),
    .all_idle    (all_idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every go pulse must match the oldest expected job.
  always @(negedge clk) begin : sb_mon
    job_t e;
    if (!rst && unit_go != 4'b0000) begin
      if (sb.size() == 0) begin
        check("go_unexpected", {28'h0, unit_go}, 32'h0);
      end else begin
        e = sb.pop_front();
        check("go_unit", {28'h0, unit_go}, 32'(4'b0001 << e.unit));
        check("go_n", {24'h0, unit_n}, {24'h0, e.n});
      end
      go_times.push_back(cyc);
    end
  end

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    input_addr   = addr;
    write_data   = data;
    write_enable = 1'b1;
    @(negedge clk);
    write_enable = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    input_addr = addr;
    #1;
    check(tag, read_data, exp);
  endtask

  task automatic pulse_done(input logic [3:0] mask);
    done = mask;
    @(negedge clk);
    done = 4'b0000;
  endtask

  task automatic wait_sb(input int target, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (sb.size() <= target) break;
      @(negedge clk);
    end
    check("sb_drain", 32'(sb.size()), 32'(target));
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  function automatic job_t mk(input logic [1:0] u, input logic [7:0] n);
    job_t j;
    j.unit = u;
    j.n    = n;
    return j;
  endfunction

  initial begin
    checks       = 0;
    errors       = 0;
    cyc          = 0;
    rst          = 1'b1;
    input_addr   = 32'h0;
    write_enable = 1'b0;
    write_data   = 32'h0;
    done         = 4'b0000;

    // Reset values, both while held and after release.
    repeat (3) @(negedge clk);
    check("rst_go", {28'h0, unit_go}, 32'h0);
    check("rst_n", {24'h0, unit_n}, 32'h0);
    check("rst_idle", {31'h0, all_idle}, 32'h1);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_go", {28'h0, unit_go}, 32'h0);
    check("post_rst_idle", {31'h0, all_idle}, 32'h1);
    read_chk("rst_status", A_STATUS, 32'h00000400);
    read_chk("outside_window", 32'h00080004, 32'h0);

    // Single job: go one cycle after the write edge, for one cycle.
    sb.push_back(mk(2'd0, 8'd5));
    bus_write(A_JOB, 32'd5);
    check("go_latency", {28'h0, unit_go}, 32'h0);
    @(negedge clk);
    check("single_go", {28'h0, unit_go}, 32'h1);
    check("single_n", {24'h0, unit_n}, 32'd5);
    @(negedge clk);
    check("single_go_drop", {28'h0, unit_go}, 32'h0);
    check("single_n_hold", {24'h0, unit_n}, 32'd5);
    read_chk("single_status", A_STATUS, 32'h00001001);
    read_chk("single_last", A_LAST, 32'h00000500);
    read_chk("job_reads_zero", A_JOB, 32'h0);
    pulse_done(4'b0001);
    read_chk("single_done_status", A_STATUS, 32'h00001400);

    // Round robin with back-to-back writes; job 5 waits for a free unit.
    do_reset();
    go_times.delete();
    for (int i = 0; i < 4; i++) sb.push_back(mk(2'(i), 8'(i + 1)));
    sb.push_back(mk(2'd2, 8'd5));
    for (int i = 1; i <= 5; i++) bus_write(A_JOB, 32'(i));
    wait_sb(1, 40);
    read_chk("rr_status", A_STATUS, 32'h0000001F);
    check("rr_go_count", 32'(go_times.size()), 32'd4);
    for (int i = 1; i < go_times.size(); i++) begin
      check("rr_spacing", 32'(go_times[i] - go_times[i-1]), 32'd3);
    end
    pulse_done(4'b0100);
    wait_sb(0, 20);
    read_chk("rr_last", A_LAST, 32'h00000502);
    read_chk("rr_status2", A_STATUS, 32'h0000300F);

    // Overflow with all units busy, then clear flags and flush.
    for (int i = 0; i < 6; i++) bus_write(A_JOB, 32'(10 + i));
    read_chk("ovf_status", A_STATUS, 32'h0000314F);
    bus_write(A_CTRL, 32'h1);
    read_chk("ovf_clear", A_STATUS, 32'h0000304F);
    bus_write(A_CTRL, 32'h2);
    read_chk("flush", A_STATUS, 32'h0000300F);
    read_chk("ctrl_reads_zero", A_CTRL, 32'h0);

    // Release every unit, then a done on an idle unit.
    pulse_done(4'b1111);
    read_chk("all_free", A_STATUS, 32'h00003400);
    pulse_done(4'b0010);
    read_chk("spurious", A_STATUS, 32'h00003600);
    sb.push_back(mk(2'd3, 8'd7));
    bus_write(A_JOB, 32'd7);
    wait_sb(0, 20);
    read_chk("after_spurious", A_STATUS, 32'h00000208);

    // Reset while unit 1 is being started.
    sb.push_back(mk(2'd0, 8'd8));
    sb.push_back(mk(2'd1, 8'd9));
    bus_write(A_JOB, 32'd8);
    bus_write(A_JOB, 32'd9);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (unit_go == 4'b0010) begin
        found = 1'b1;
        break;
      end
    end
    check("mid_issue_seen", {31'h0, found}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("async_go_drop", {28'h0, unit_go}, 32'h0);
    check("async_idle", {31'h0, all_idle}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    read_chk("post_mid_rst_status", A_STATUS, 32'h00000400);
    check("post_mid_rst_go", {28'h0, unit_go}, 32'h0);
    check("sb_final", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
